// File: rtl/fsm_cordic_hyp_ctrl.sv
// Control FSM for the floating-point hyperbolic CORDIC datapath.
// This module sequences the LN and EXP evaluations. It supports a programmable
// iteration count, the hyperbolic repeat iterations (4, 13, 40), order-independent
// ACK collection from the X, Y and Z adders, and an ACK-wait timeout.
module fsm_cordic_hyp_ctrl #(
  parameter int ITER_W    = 6,
  parameter int N_ITER    = 15,
  parameter bit REPEAT_EN = 1'b1,
  parameter int TO_W      = 8
) (
  input  logic              CLK,
  input  logic              RST_LN,
  input  logic              START,
  input  logic              MODE,
  input  logic              ACK_ADD_SUBTX,
  input  logic              ACK_ADD_SUBTY,
  input  logic              ACK_ADD_SUBTZ,
  output logic              RST,
  output logic              MS_1,
  output logic              MS_2,
  output logic              MS_3,
  output logic              EN_MS1,
  output logic              EN_MS2,
  output logic              EN_MS3,
  output logic              EN_ADDSUBT,
  output logic              ADD_SUBT,
  output logic              Begin_SUMX,
  output logic              Begin_SUMY,
  output logic              Begin_SUMZ,
  output logic              EN_REG1X,
  output logic              EN_REG1Y,
  output logic              EN_REG1Z,
  output logic              EN_REG2,
  output logic              EN_REG2XYZ,
  output logic              EN_REG3,
  output logic              EN_REG4,
  output logic [ITER_W-1:0] ITER,
  output logic              BUSY,
  output logic              ACK_LN,
  output logic              ERR
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_SEL     = 4'd1;
  localparam logic [3:0] S_LOAD    = 4'd2;
  localparam logic [3:0] S_PRE     = 4'd3;
  localparam logic [3:0] S_PRE_W   = 4'd4;
  localparam logic [3:0] S_SHIFT   = 4'd5;
  localparam logic [3:0] S_CAPT    = 4'd6;
  localparam logic [3:0] S_ROT     = 4'd7;
  localparam logic [3:0] S_ROT_W   = 4'd8;
  localparam logic [3:0] S_NEXT    = 4'd9;
  localparam logic [3:0] S_FIN_SEL = 4'd10;
  localparam logic [3:0] S_FIN     = 4'd11;
  localparam logic [3:0] S_FIN_W   = 4'd12;
  localparam logic [3:0] S_DONE    = 4'd13;

  // This is the last counter value before the limit. It is the (2^TO_W-1)-th wait cycle.
  localparam logic [TO_W-1:0] TO_LIM = {{(TO_W-1){1'b1}}, 1'b0};

  logic [3:0]        state;
  logic [3:0]        state_nxt;
  logic [ITER_W-1:0] iter_q;
  logic              rep_done;
  logic              ack_x;
  logic              ack_y;
  logic              ack_z;
  logic [TO_W-1:0]   to_cnt;
  logic              mode_q;
  logic              err_q;

  logic              in_wait;
  logic              got_x;
  logic              got_y;
  logic              got_z;
  logic              wait_done;
  logic              timeout;
  logic [31:0]       iter_int;
  logic              rep_hit;
  logic              last_iter;

  assign iter_int  = 32'(iter_q);
  assign rep_hit   = REPEAT_EN && !rep_done &&
                     (iter_int == 32'd4 || iter_int == 32'd13 || iter_int == 32'd40);
  assign last_iter = (iter_int == 32'(N_ITER));

  assign in_wait = (state == S_PRE_W) || (state == S_ROT_W) || (state == S_FIN_W);
  // A same-cycle ACK counts toward completion. Completion therefore wins over the timeout.
  assign got_x   = ack_x | ACK_ADD_SUBTX;
  assign got_y   = ack_y | ACK_ADD_SUBTY;
  assign got_z   = ack_z | ACK_ADD_SUBTZ;

  // This block computes the completion condition for the wait state that is currently active.
  always_comb begin
    wait_done = 1'b0;
    case (state)
      S_PRE_W: wait_done = got_x & got_y;
      S_ROT_W: wait_done = got_x & got_y & got_z;
      S_FIN_W: wait_done = mode_q ? got_x : got_z;
      default: wait_done = 1'b0;
    endcase
  end

  assign timeout = in_wait && !wait_done && (to_cnt == TO_LIM);

  assign ITER   = iter_q;
  assign BUSY   = (state != S_IDLE);
  assign ACK_LN = (state == S_DONE);
  assign ERR    = err_q;

  // This block updates the state register, the iteration bookkeeping, the ACK flags, the timeout counter and the error flag.
  always_ff @(posedge CLK) begin
    if (RST_LN) begin
      state    <= S_IDLE;
      iter_q   <= ITER_W'(1);
      rep_done <= 1'b0;
      ack_x    <= 1'b0;
      ack_y    <= 1'b0;
      ack_z    <= 1'b0;
      to_cnt   <= '0;
      mode_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      to_cnt <= in_wait ? to_cnt + TO_W'(1) : '0;

      if (state == S_IDLE && START) begin
        mode_q <= MODE;
      end

      if (state == S_PRE || state == S_ROT || state == S_FIN) begin
        ack_x <= 1'b0;
        ack_y <= 1'b0;
        ack_z <= 1'b0;
      end else if (in_wait) begin
        ack_x <= got_x;
        ack_y <= got_y;
        ack_z <= got_z;
      end

      if (state == S_NEXT) begin
        if (rep_hit) begin
          rep_done <= 1'b1;
        end else if (!last_iter) begin
          iter_q   <= iter_q + ITER_W'(1);
          rep_done <= 1'b0;
        end
      end

      if (timeout) begin
        err_q <= 1'b1;
      end

      if (state == S_DONE && !START) begin
        iter_q   <= ITER_W'(1);
        rep_done <= 1'b0;
        err_q    <= 1'b0;
      end
    end
  end

  // This block decodes the next state and all datapath strobes from the registered state.
  always_comb begin
    state_nxt  = state;
    RST        = 1'b0;
    MS_1       = 1'b0;
    MS_2       = 1'b0;
    MS_3       = 1'b0;
    EN_MS1     = 1'b0;
    EN_MS2     = 1'b0;
    EN_MS3     = 1'b0;
    EN_ADDSUBT = 1'b0;
    ADD_SUBT   = 1'b0;
    Begin_SUMX = 1'b0;
    Begin_SUMY = 1'b0;
    Begin_SUMZ = 1'b0;
    EN_REG1X   = 1'b0;
    EN_REG1Y   = 1'b0;
    EN_REG1Z   = 1'b0;
    EN_REG2    = 1'b0;
    EN_REG2XYZ = 1'b0;
    EN_REG3    = 1'b0;
    EN_REG4    = 1'b0;
    case (state)
      S_IDLE: begin
        if (START) begin
          RST       = 1'b1;
          state_nxt = S_SEL;
        end
      end
      S_SEL: begin
        EN_MS1     = 1'b1;
        EN_MS2     = 1'b1;
        EN_MS3     = 1'b1;
        EN_ADDSUBT = 1'b1;
        MS_1       = !mode_q;
        MS_2       = !mode_q;
        state_nxt  = S_LOAD;
      end
      S_LOAD: begin
        EN_REG3 = 1'b1;
        if (mode_q) begin
          EN_REG1X  = 1'b1;
          EN_REG1Y  = 1'b1;
          EN_REG1Z  = 1'b1;
          state_nxt = S_SHIFT;
        end else begin
          state_nxt = S_PRE;
        end
      end
      S_PRE: begin
        Begin_SUMX = 1'b1;
        Begin_SUMY = 1'b1;
        state_nxt  = S_PRE_W;
      end
      S_PRE_W: begin
        if (wait_done) begin
          EN_REG1X  = 1'b1;
          EN_REG1Y  = 1'b1;
          EN_REG1Z  = 1'b1;
          EN_MS1    = 1'b1;
          EN_MS2    = 1'b1;
          state_nxt = S_SHIFT;
        end else if (timeout) begin
          state_nxt = S_DONE;
        end
      end
      S_SHIFT: begin
        EN_REG2   = 1'b1;
        state_nxt = S_CAPT;
      end
      S_CAPT: begin
        EN_REG2XYZ = 1'b1;
        state_nxt  = S_ROT;
      end
      S_ROT: begin
        Begin_SUMX = 1'b1;
        Begin_SUMY = 1'b1;
        Begin_SUMZ = 1'b1;
        state_nxt  = S_ROT_W;
      end
      S_ROT_W: begin
        if (wait_done) begin
          EN_REG1X  = 1'b1;
          EN_REG1Y  = 1'b1;
          EN_REG1Z  = 1'b1;
          state_nxt = S_NEXT;
        end else if (timeout) begin
          state_nxt = S_DONE;
        end
      end
      S_NEXT: begin
        if (rep_hit) begin
          state_nxt = S_SHIFT;
        end else if (last_iter) begin
          state_nxt = S_FIN_SEL;
        end else begin
          state_nxt = S_SHIFT;
        end
      end
      S_FIN_SEL: begin
        MS_3       = 1'b1;
        EN_MS3     = 1'b1;
        EN_ADDSUBT = 1'b1;
        state_nxt  = S_FIN;
      end
      S_FIN: begin
        if (mode_q) begin
          Begin_SUMX = 1'b1;
        end else begin
          Begin_SUMZ = 1'b1;
        end
        state_nxt = S_FIN_W;
      end
      S_FIN_W: begin
        if (wait_done) begin
          EN_REG4   = 1'b1;
          state_nxt = S_DONE;
        end else if (timeout) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (!START) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: doc/fsm_cordic_hyp_ctrl.md
Name: fsm_cordic_hyp_ctrl

Overview:
- Parametrised control FSM for the floating-point hyperbolic CORDIC datapath (X/Y/Z add/sub units, shift stage, selector muxes). Successor to the fixed 15-iteration LN controller.
- Adds programmable iteration count, an internal iteration counter, and the hyperbolic repeat iterations (4, 13, 40).
- Adds a second mode (EXP: final X+Y), order-independent ACK collection and an ACK-timeout error.
- Sits between the top-level LN/EXP wrapper and the shared CORDIC datapath.

Parameters:
ITER_W, 6, width of iteration index / shift amount output
N_ITER, 15, last iteration index (indices run 1..N_ITER); legal 1..2^ITER_W-1
REPEAT_EN, 1, 1 = indices 4, 13, 40 (when <= N_ITER) are executed twice
TO_W, 8, ACK-wait timeout counter width; timeout at 2^TO_W-1 cycles

Ports:
CLK  in  1  system clock
RST_LN  in  1  synchronous active-high reset
START  in  1  level; sampled in IDLE
MODE  in  1  0 = LN, 1 = EXP; latched when START is accepted
ACK_ADD_SUBTX  in  1  X adder done (single-cycle or level)
ACK_ADD_SUBTY  in  1  Y adder done
ACK_ADD_SUBTZ  in  1  Z adder done
RST  out  1  datapath register reset pulse
MS_1, MS_2, MS_3  out  1 each  mux selects
EN_MS1, EN_MS2, EN_MS3, EN_ADDSUBT  out  1 each  selector-register enables
ADD_SUBT  out  1  0 = add, 1 = subtract
Begin_SUMX, Begin_SUMY, Begin_SUMZ  out  1 each  adder start pulses
EN_REG1X, EN_REG1Y, EN_REG1Z, EN_REG2, EN_REG2XYZ, EN_REG3, EN_REG4  out  1 each  register enables
ITER  out  ITER_W  current shift index
BUSY  out  1  high in any state other than IDLE
ACK_LN  out  1  result valid (held)
ERR  out  1  timeout occurred (held with ACK_LN)

Behaviour:
- Reset: RST_LN=1 at a CLK edge gives state IDLE, ITER=1, rep_done=0, ack flags cleared, timeout counter=0, mode_q=0, ERR=0.
- Reset overrides every state, including mid-rotation. All combinational outputs are 0 in IDLE except as stated below.
- All strobes are Moore/Mealy single-cycle pulses, decoded combinationally from the registered state.

States:
- IDLE: if START, RST=1, latch MODE, then go to SEL. Otherwise stay.
- SEL: EN_MS1/2/3=1, EN_ADDSUBT=1, ADD_SUBT=0.
  - LN: MS_1=1, MS_2=1, MS_3=0.
  - EXP: MS_1=0, MS_2=0, MS_3=0.
  - Next state: LOAD.
- LOAD: EN_REG3=1.
  - LN: go to PRE.
  - EXP: EN_REG1X/Y/Z=1, go to SHIFT (pre-add skipped).
- PRE: Begin_SUMX=Begin_SUMY=1, go to PRE_W.
- PRE_W: wait until X and Y flags are both set.
  - Then EN_REG1X/Y/Z=1, MS_1=0, MS_2=0, EN_MS1=EN_MS2=1, go to SHIFT.
- SHIFT: EN_REG2=1, go to CAPT.
- CAPT: EN_REG2XYZ=1, go to ROT.
- ROT: Begin_SUMX=Begin_SUMY=Begin_SUMZ=1 in the same cycle; clear ack flags; go to ROT_W.
- ROT_W: collect ACKs into sticky flags (an ACK may arrive in any cycle order and need not be held).
  - When all three flags are set: EN_REG1X/Y/Z=1, go to NEXT.
- NEXT (iteration bookkeeping):
  - If REPEAT_EN, ITER is in {4, 13, 40} and rep_done=0: rep_done=1, ITER unchanged, go to SHIFT.
  - Else if ITER==N_ITER: go to FIN_SEL.
  - Else: ITER+1, rep_done=0, go to SHIFT.
- FIN_SEL: MS_3=1, EN_MS3=1, ADD_SUBT=0, EN_ADDSUBT=1, go to FIN.
- FIN: LN: Begin_SUMZ=1. EXP: Begin_SUMX=1. Go to FIN_W.
- FIN_W: wait for the Z flag (LN) or X flag (EXP); then EN_REG4=1, go to DONE.
- DONE: ACK_LN=1 (and ERR if set).
  - Stay while START=1.
  - When START=0: go to IDLE, ITER=1, ERR=0.

Iteration count and timeout:
- Rotation count = N_ITER + number of repeat indices <= N_ITER (when REPEAT_EN). Default config gives 17 rotations.
- Timeout counter clears on entry to any _W state and increments each cycle in it.
- At 2^TO_W-1 without completion: ERR=1, go to DONE (EN_REG4 not asserted).
- An ACK arriving on the same cycle as the timeout counts: completion wins over timeout.
- ACKs arriving outside _W states are ignored.
- START rising while the FSM is busy is ignored.

Test Plan:
- LN, defaults, all ACKs 2 cycles after their Begin: exactly 17 ROT pulses; ITER sequence 1,2,3,4,4,5..13,13,14,15; one EN_REG4; ACK_LN stays high until START drops, then IDLE.
- REPEAT_EN=0, N_ITER=15: 15 ROT pulses, ITER 1..15; N_ITER=1: one rotation, then FIN.
- EXP mode: no PRE pulse; final Begin_SUMX only (Begin_SUMZ absent in FIN); MS_3=1 during FIN_SEL.
- Skewed ACKs in ROT_W: Z at +1, X at +5, Y at +9 cycles, each a 1-cycle pulse: EN_REG1X/Y/Z asserted exactly at +9, no earlier.
- Y ACK withheld, TO_W=4: ERR=1 and ACK_LN=1 after 15 wait cycles; EN_REG4 never pulsed.
- RST_LN asserted for 1 cycle mid ROT_W (ITER=7): next cycle IDLE, ITER=1, all outputs 0; a fresh START runs a full sequence correctly.
